// File: rtl/data_memory_if.sv
// Memory-stage bus, console byte stream and exit status shared between a core
// and the data memory.
interface data_memory_if;
    logic [31:0] memory_address;
    logic [3:0]  memory_byte_enable;
    logic [31:0] memory_write;
    logic        memory_we;
    logic [31:0] memory_read;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;
    logic        halt;
    logic [31:0] exit_code;

    modport master (
        output memory_address, memory_byte_enable, memory_write, memory_we, console_ready,
        input  memory_read, console_data, console_valid, halt, exit_code
    );

    modport slave (
        input  memory_address, memory_byte_enable, memory_write, memory_we, console_ready,
        output memory_read, console_data, console_valid, halt, exit_code
    );
endinterface

// File: rtl/data_memory.sv
// Data memory: word RAM with byte-lane writes plus MMIO console FIFO, cycle
// counter with high-word shadow, and a one-shot exit register.
module data_memory #(
    parameter int unsigned WORDS         = 1024,
    parameter int unsigned CONSOLE_DEPTH = 8
) (
    input logic         clk,
    input logic         rst,
    data_memory_if.slave bus
);
    localparam int unsigned AW = $clog2(WORDS);
    localparam int unsigned PW = $clog2(CONSOLE_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [31:0] ADDR_CONSOLE = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_STATUS  = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_CNT_LO  = 32'hFFFF_FF08;
    localparam logic [31:0] ADDR_CNT_HI  = 32'hFFFF_FF0C;
    localparam logic [31:0] ADDR_EXIT    = 32'hFFFF_FF10;

    logic [31:0]   ram [WORDS];
    logic [AW-1:0] ram_index;
    logic [29:0]   word_addr;
    logic          is_ram, is_console, is_status, is_cnt_lo, is_cnt_hi, is_exit;
    logic          unused_addr_bits;

    logic [63:0]   counter_q;
    logic [31:0]   shadow_q;

    logic [7:0]    fifo_mem [CONSOLE_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push_req, push, pop, overflow_set;
    logic          overflow_q;
    logic [3:0]    count_sat;
    logic [31:0]   status;

    logic          halt_q;
    logic [31:0]   exit_code_q;

    // Address decode on the word address; byte offset is deliberately ignored.
    always_comb begin
        word_addr  = bus.memory_address[31:2];
        ram_index  = bus.memory_address[AW+1:2];
        is_ram     = (bus.memory_address[31:AW+2] == '0);
        is_console = (word_addr == ADDR_CONSOLE[31:2]);
        is_status  = (word_addr == ADDR_STATUS[31:2]);
        is_cnt_lo  = (word_addr == ADDR_CNT_LO[31:2]);
        is_cnt_hi  = (word_addr == ADDR_CNT_HI[31:2]);
        is_exit    = (word_addr == ADDR_EXIT[31:2]);
    end

    assign unused_addr_bits = ^bus.memory_address[1:0];

    // RAM lane writes; contents are never reset and writes under reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst && bus.memory_we && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.memory_byte_enable[i]) begin
                    ram[ram_index][8*i +: 8] <= bus.memory_write[8*i +: 8];
                end
            end
        end
    end

    // Free-running cycle counter and high-word shadow captured on CNT_LO reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q <= '0;
            shadow_q  <= '0;
        end else begin
            counter_q <= counter_q + 64'd1;
            if (is_cnt_lo && !bus.memory_we) begin
                shadow_q <= counter_q[63:32];
            end
        end
    end

    // FIFO handshake: a full FIFO still accepts a push when the head pops.
    always_comb begin
        full         = (count_q == CW'(CONSOLE_DEPTH));
        empty        = (count_q == '0);
        push_req     = bus.memory_we && is_console && bus.memory_byte_enable[0];
        pop          = !empty && bus.console_ready;
        push         = push_req && (!full || pop);
        overflow_set = push_req && full && !pop;
        count_d      = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        count_sat = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
        status    = {24'b0, count_sat, overflow_q, empty, full, halt_q};
    end

    // FIFO storage; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[tail_q] <= bus.memory_write[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow (new overflow beats STATUS clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_d;
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (bus.memory_we && is_status) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Exit register: first write wins, halt stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q      <= 1'b0;
            exit_code_q <= '0;
        end else if (bus.memory_we && is_exit && !halt_q) begin
            halt_q      <= 1'b1;
            exit_code_q <= bus.memory_write;
        end
    end

    // Zero-latency read mux; unmapped addresses (including CONSOLE) read as zero.
    always_comb begin
        bus.memory_read = '0;
        if (is_ram) begin
            bus.memory_read = ram[ram_index];
        end else if (is_status) begin
            bus.memory_read = status;
        end else if (is_cnt_lo) begin
            bus.memory_read = counter_q[31:0];
        end else if (is_cnt_hi) begin
            bus.memory_read = shadow_q;
        end else if (is_exit) begin
            bus.memory_read = exit_code_q;
        end
    end

    assign bus.console_data  = fifo_mem[head_q];
    assign bus.console_valid = !empty;
    assign bus.halt          = halt_q;
    assign bus.exit_code     = exit_code_q;
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the driver queues expected values, the
// negedge monitor pops and compares them, and checks every console pop in order.
module tb_data_memory;
    localparam logic [31:0] A_CONSOLE = 32'hFFFF_FF00;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_FF04;
    localparam logic [31:0] A_CNT_LO  = 32'hFFFF_FF08;
    localparam logic [31:0] A_CNT_HI  = 32'hFFFF_FF0C;
    localparam logic [31:0] A_EXIT    = 32'hFFFF_FF10;

    typedef enum int {KRead, KValid, KData, KHalt, KExit} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic [7:0] con_q[$];

    always #5 clk = ~clk;

    data_memory_if bus ();

    data_memory #(.WORDS(1024), .CONSOLE_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic drive(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                         input logic we, input logic rdy);
        @(posedge clk);
        #1;
        bus.memory_address     = addr;
        bus.memory_byte_enable = be;
        bus.memory_write       = wd;
        bus.memory_we          = we;
        bus.console_ready      = rdy;
    endtask

    task automatic expect_out(input string name, input kind_t kind, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Monitor: compare queued expectations and console pops away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        logic [7:0]  b;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                KRead:   act = bus.memory_read;
                KValid:  act = {31'b0, bus.console_valid};
                KData:   act = {24'b0, bus.console_data};
                KHalt:   act = {31'b0, bus.halt};
                KExit:   act = bus.exit_code;
                default: act = 'x;
            endcase
            tests++;
            if (act !== e.value) begin
                fails++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.value);
            end
        end
        if (bus.console_valid === 1'b1 && bus.console_ready === 1'b1) begin
            tests++;
            if (con_q.size() == 0) begin
                fails++;
                $display("FAIL console_pop: got %h, expected no byte", bus.console_data);
            end else begin
                b = con_q.pop_front();
                if (bus.console_data !== b) begin
                    fails++;
                    $display("FAIL console_pop: got %h, expected %h", bus.console_data, b);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bus.memory_address     = '0;
        bus.memory_byte_enable = '0;
        bus.memory_write       = '0;
        bus.memory_we          = 1'b0;
        bus.console_ready      = 1'b0;

        // Reset, with a console push that must be discarded.
        rst = 1'b1;
        drive(32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        drive(A_CONSOLE, 4'h1, 32'h77, 1'b1, 1'b0);
        drive(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        expect_out("reset_status", KRead, 32'h04);
        expect_out("reset_valid", KValid, 32'h0);
        expect_out("reset_halt", KHalt, 32'h0);
        expect_out("reset_exit", KExit, 32'h0);
        drive(A_CNT_HI, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("reset_cnt_hi", KRead, 32'h0);

        // RAM and unmapped aliasing just above the top of RAM.
        drive(32'h0, 4'hF, 32'h1234_5678, 1'b1, 1'b0);
        drive(32'h1000, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0);
        drive(32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("ram_word0", KRead, 32'h1234_5678);
        drive(32'h1000, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("unmapped_read", KRead, 32'h0);

        // Byte-lane write and read-during-write.
        drive(32'h10, 4'hF, 32'hAABB_CCDD, 1'b1, 1'b0);
        drive(32'h10, 4'h2, 32'h0000_1100, 1'b1, 1'b0);
        expect_out("ram_during_write", KRead, 32'hAABB_CCDD);
        drive(32'h13, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("ram_lane_write", KRead, 32'hAABB_11DD);

        // Fill the console FIFO past capacity with the sink stalled.
        for (int i = 0; i < 9; i++) begin
            drive(A_CONSOLE, 4'h1, {24'hABCDEF, 8'(8'h41 + i)}, 1'b1, 1'b0);
            if (i < 8) con_q.push_back(8'(8'h41 + i));
        end
        drive(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("status_full_ovf", KRead, 32'h8A);
        expect_out("console_head", KData, 32'h41);
        drive(A_STATUS, 4'hF, 32'h0, 1'b1, 1'b0);
        expect_out("status_during_clear", KRead, 32'h8A);
        drive(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("status_ovf_cleared", KRead, 32'h82);

        // Push and pop together on a full FIFO.
        drive(A_CONSOLE, 4'h1, 32'h50, 1'b1, 1'b1);
        con_q.push_back(8'h50);
        drive(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("status_push_pop_full", KRead, 32'h82);
        for (int n = 0; n < 20 && con_q.size() > 0; n++) begin
            drive(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b1);
        end
        drive(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("status_drained", KRead, 32'h04);

        // Push into an empty FIFO is not visible until the next cycle.
        drive(A_CONSOLE, 4'h1, 32'h60, 1'b1, 1'b1);
        con_q.push_back(8'h60);
        expect_out("no_bypass_valid", KValid, 32'h0);
        drive(32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        expect_out("push_valid_next", KValid, 32'h1);
        expect_out("push_data_next", KData, 32'h60);
        drive(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("status_empty_again", KRead, 32'h04);

        // Counter low word about to carry: CNT_HI must return the shadow.
        drive(A_CNT_LO, 4'h0, 32'h0, 1'b0, 1'b0);
        force dut.counter_q = 64'h0000_0000_FFFF_FFFF;
        expect_out("cnt_lo", KRead, 32'hFFFF_FFFF);
        drive(A_CNT_HI, 4'h0, 32'h0, 1'b0, 1'b0);
        release dut.counter_q;
        expect_out("cnt_hi_shadow", KRead, 32'h0);

        // Exit register: first write wins, byte enables ignored.
        drive(A_EXIT, 4'h0, 32'd5, 1'b1, 1'b0);
        expect_out("halt_before_edge", KHalt, 32'h0);
        drive(A_EXIT, 4'hF, 32'd7, 1'b1, 1'b0);
        expect_out("halt_set", KHalt, 32'h1);
        expect_out("exit_first", KExit, 32'd5);
        drive(A_EXIT, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("exit_sticky", KExit, 32'd5);
        expect_out("exit_read", KRead, 32'd5);
        drive(A_STATUS, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("status_halted", KRead, 32'h05);

        // Reset clears halt/exit but leaves RAM alone, ignoring a write under reset.
        drive(32'h10, 4'hF, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        drive(32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        expect_out("rst_halt", KHalt, 32'h0);
        expect_out("rst_exit", KExit, 32'h0);
        expect_out("rst_ram_word0", KRead, 32'h1234_5678);
        drive(32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
        expect_out("rst_ram_word4", KRead, 32'hAABB_11DD);
        drive(32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);

        tests++;
        if (con_q.size() != 0) begin
            fails++;
            $display("FAIL console_leftover: got %0d bytes, expected 0", con_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
